// File: rtl/uart_pkg.sv
// Shared constants and helpers for the parametrised UART transmit path.
// Holds the parity encodings, the frame-length formula and the parity-bit calculation.
package uart_pkg;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_ODD    = 1;
    localparam int PARITY_EVEN   = 2;
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SHIFT
    } tx_state_e;

    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

    // Callers zero-extend the payload, so unused upper bits do not disturb the XOR.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with an occupancy count; the head word is always visible on rd_data.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign count   = count_q;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is deliberately left out of reset; the count and pointers alone define validity,
    // and keeping the array reset-free lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter: a valid/ready push port feeds a FIFO that a serializer drains
// into back-to-back frames of start, LSB-first data, optional parity and stop bits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 9_600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BAUD_DIV   = CLK_HZ / BAUD;
    localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam int CNT_W      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int IDX_W      = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    if (BAUD_DIV < 2) begin : g_chk_baud
        $error("uart_tx_fifo: CLK_HZ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_chk_data
        $error("uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_chk_par
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end

    logic [DATA_BITS-1:0]      fifo_rd_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic [FRAME_BITS-1:0]     frame_load;

    tx_state_e                 state_q, state_d;
    logic                      tx_q, tx_d;
    logic [FRAME_BITS-1:0]     shreg_q, shreg_d;
    logic [CNT_W-1:0]          baud_q, baud_d;
    logic [IDX_W-1:0]          idx_q, idx_d;

    assign in_ready   = ~fifo_full;
    assign push       = in_valid && in_ready;
    assign fifo_level = fifo_count;
    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Whole frame, transmit order from bit 0: start, payload, optional parity, stop bits.
    if (PARITY != PARITY_NONE) begin : g_par
        assign frame_load = {{STOP_BITS{1'b1}},
                             parity_bit(MAX_DATA_BITS'(fifo_rd_data), PARITY),
                             fifo_rd_data, 1'b0};
    end else begin : g_nopar
        assign frame_load = {{STOP_BITS{1'b1}}, fifo_rd_data, 1'b0};
    end

    // NOTE: every output of this block is given a default before the case, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        shreg_d = shreg_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                idx_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    tx_d    = frame_load[0];
                    shreg_d = frame_load >> 1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (idx_q == IDX_LAST) begin
                        // End of the last stop bit: chain straight into the next frame if one is queued.
                        idx_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            tx_d    = frame_load[0];
                            shreg_d = frame_load >> 1;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        idx_d   = idx_q + IDX_ONE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            shreg_q <= '1;
            baud_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            shreg_q <= shreg_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three instances (8N1, 7E2, 8O1) at BAUD_DIV=10; stimulus pushes
// expected line waveforms into a queue and per-line monitors compare every clock of each frame.
module tb_uart_tx_fifo;

    localparam int DIV = 10;

    typedef struct {
        int          idx;
        logic [15:0] bits;
        int          nbits;
        bit          gap0;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;
    logic       v0, v1, v2;
    logic       r0, r1, r2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic [4:0] lvl0, lvl1, lvl2;
    logic [2:0] tx_v;

    assign tx_v = {tx2, tx1, tx0};

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0), .in_ready(r0),
        .tx(tx0), .busy(busy0), .fifo_level(lvl0));

    uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) u_7e2 (
        .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_ready(r1),
        .tx(tx1), .busy(busy1), .fifo_level(lvl1));

    uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2), .in_ready(r2),
        .tx(tx2), .busy(busy2), .fifo_level(lvl2));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic rdy_of(input int idx);
        return (idx == 0) ? r0 : (idx == 1) ? r1 : r2;
    endfunction
    function automatic logic busy_of(input int idx);
        return (idx == 0) ? busy0 : (idx == 1) ? busy1 : busy2;
    endfunction
    function automatic logic [4:0] lvl_of(input int idx);
        return (idx == 0) ? lvl0 : (idx == 1) ? lvl1 : lvl2;
    endfunction

    task automatic set_valid(input int idx, input logic [8:0] d, input logic v);
        case (idx)
            0:       begin d0 = d[7:0]; v0 = v; end
            1:       begin d1 = d[6:0]; v1 = v; end
            default: begin d2 = d[7:0]; v2 = v; end
        endcase
    endtask

    // Presents a word from a falling edge and returns just after the accepting rising edge.
    // With hold=0 in_valid is dropped 1 time unit later, before the next edge.
    task automatic push(input int idx, input logic [8:0] d, input bit hold, output int stalls);
        bit rdy;
        bit done;
        stalls = 0;
        done   = 1'b0;
        @(negedge clk);
        set_valid(idx, d, 1'b1);
        for (int n = 0; n < 400 && !done; n++) begin
            rdy = rdy_of(idx);
            @(posedge clk);
            if (rdy) begin
                done = 1'b1;
            end else begin
                stalls++;
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout u%0d: word %0h not accepted within 400 cycles", idx, d);
        end
        if (!hold) begin
            #1 set_valid(idx, d, 1'b0);
        end
    endtask

    // One isolated frame: checks the two-edge start latency and the exact cycle busy drops.
    task automatic one_frame(input int idx, input logic [8:0] d, input logic [15:0] bits,
                             input int nbits, input string name);
        int stalls;
        sb_q.push_back('{idx: idx, bits: bits, nbits: nbits, gap0: 1'b0});
        push(idx, d, 1'b0, stalls);
        @(negedge clk);
        check({name, "_tx_before_start"}, 32'(tx_v[idx]), 32'd1);
        @(negedge clk);
        check({name, "_tx_start"}, 32'(tx_v[idx]), 32'd0);
        repeat (nbits * DIV - 1) @(negedge clk);
        check({name, "_busy_last_cycle"}, 32'(busy_of(idx)), 32'd1);
        @(negedge clk);
        check({name, "_busy_drop"}, 32'(busy_of(idx)), 32'd0);
        check({name, "_tx_idle"}, 32'(tx_v[idx]), 32'd1);
    endtask

    task automatic wait_idle(input int idx, input int budget, input string name);
        int n;
        n = 0;
        while (busy_of(idx) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy_of(idx)) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, budget);
        end
    endtask

    // Per-line monitor: on each start bit pops the next expectation and compares all
    // nbits*DIV samples, plus the idle gap before the frame when back-to-back is required.
    task automatic monitor(input int idx);
        exp_t e;
        int   gap;
        bit   ok;
        bit   abort;
        int   bad_bit;
        logic bad_val;
        gap = 1000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gap = 1000;
            end else if (tx_v[idx] !== 1'b0) begin
                if (gap < 1000) gap++;
            end else if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame u%0d: start bit seen, expected none queued", idx);
                repeat (12 * DIV) @(negedge clk);
                gap = 1000;
            end else begin
                e       = sb_q.pop_front();
                ok      = 1'b1;
                abort   = 1'b0;
                bad_bit = 0;
                bad_val = 1'b0;
                for (int i = 0; i < e.nbits && !abort; i++) begin
                    for (int s = 0; s < DIV && !abort; s++) begin
                        if (i != 0 || s != 0) @(negedge clk);
                        if (!rst_n) begin
                            abort = 1'b1;
                        end else if (ok && tx_v[idx] !== e.bits[i]) begin
                            ok      = 1'b0;
                            bad_bit = i;
                            bad_val = tx_v[idx];
                        end
                    end
                end
                if (abort) begin
                    gap = 1000;
                end else begin
                    checks++;
                    if (!ok || e.idx != idx) begin
                        errors++;
                        $display("FAIL frame u%0d: bit %0d got %b expected %b (frame %0h, for u%0d)",
                                 idx, bad_bit, bad_val, e.bits[bad_bit], e.bits, e.idx);
                    end
                    if (e.gap0) begin
                        checks++;
                        if (gap != 0) begin
                            errors++;
                            $display("FAIL gap u%0d: got %0d idle cycles before frame %0h, expected 0",
                                     idx, gap, e.bits);
                        end
                    end
                    gap = 0;
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          stalls;
        logic [7:0]  w;
        d0 = '0; d1 = '0; d2 = '0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_tx_u%0d", i),    32'(tx_v[i]),     32'd1);
            check($sformatf("rst_ready_u%0d", i), 32'(rdy_of(i)),   32'd1);
            check($sformatf("rst_busy_u%0d", i),  32'(busy_of(i)),  32'd0);
            check($sformatf("rst_level_u%0d", i), 32'(lvl_of(i)),   32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // tx = 0,0,0,0,1,0,0,1,0,1
        one_frame(0, 9'h48, 16'h0290, 10, "8n1_48");
        // tx = 0,1,0,1,0,1,0,1,0,1,1
        one_frame(1, 9'h55, 16'h06AA, 11, "7e2_55");
        // tx = 0,1,0,1,1,0,0,0,0,0(parity),1
        one_frame(2, 9'h0D, 16'h041A, 11, "8o1_0d");

        // 18 words with in_valid held: FIFO fills at 16 and the 18th waits for the second pop.
        for (int k = 0; k < 18; k++) begin
            w = 8'(k * 37 + 3);
            sb_q.push_back('{idx: 0, bits: {6'b0, 1'b1, w, 1'b0}, nbits: 10, gap0: (k > 0)});
            push(0, {1'b0, w}, (k < 17), stalls);
            if (k == 1) begin
                #1 check("level_push_pop", 32'(lvl0), 32'd1);
            end
            if (k == 16) begin
                #1;
                check("level_full",  32'(lvl0), 32'd16);
                check("ready_full",  32'(r0),   32'd0);
            end
            if (k == 17) begin
                check("full_stall_cycles", 32'(stalls), 32'd85);
            end
        end
        wait_idle(0, 2500, "bulk_drain");
        check("bulk_level_empty", 32'(lvl0), 32'd0);

        // Reset during data bit 3 of the first of three queued frames.
        sb_q.push_back('{idx: 0, bits: 16'h0222, nbits: 10, gap0: 1'b0});
        push(0, 9'h11, 1'b1, stalls);
        sb_q.push_back('{idx: 0, bits: 16'h0244, nbits: 10, gap0: 1'b0});
        push(0, 9'h22, 1'b1, stalls);
        sb_q.push_back('{idx: 0, bits: 16'h0266, nbits: 10, gap0: 1'b0});
        push(0, 9'h33, 1'b0, stalls);
        repeat (43) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx_async", 32'(tx0),   32'd1);
        check("midrst_level",    32'(lvl0),  32'd0);
        check("midrst_busy",     32'(busy0), 32'd0);
        check("midrst_ready",    32'(r0),    32'd1);
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_tx_idle", 32'(tx0), 32'd1);
        // tx = 0,1,0,1,0,0,1,0,1,1
        one_frame(0, 9'hA5, 16'h034A, 10, "postrst_a5");

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
